// File: rtl/dpwm_pkg.sv
// Shared constants and state type for the DPWM duty stepper.
package dpwm_pkg;

  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned DEF_PERIOD    = 250;
  localparam int unsigned DEF_STEP      = 25;
  localparam int unsigned DEF_DUTY_INIT = 125;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } btn_state_e;

endpackage

// File: rtl/dpwm_sync_edge.sv
// Two-flop synchroniser with an optional rising-edge strobe.
module dpwm_sync_edge #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c
);

  logic s1;

  // Metastability filter: s1 -> q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

  generate
    if (EDGE_EN) begin : g_edge
      logic s3;

      // Delayed copy of q for edge detection.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) s3 <= 1'b0;
        else        s3 <= q;
      end

      assign rise_c = q & ~s3;
    end else begin : g_no_edge
      assign rise_c = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/dpwm_duty_stepper.sv
// Push-button duty stepper with period-aligned duty update and registered PWM output.
module dpwm_duty_stepper #(
  parameter int unsigned CNT_W     = dpwm_pkg::DEF_CNT_W,
  parameter int unsigned PERIOD    = dpwm_pkg::DEF_PERIOD,
  parameter int unsigned STEP      = dpwm_pkg::DEF_STEP,
  parameter int unsigned DUTY_INIT = dpwm_pkg::DEF_DUTY_INIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [CNT_W-1:0] duty,
  output logic             pwm_out,
  output logic             period_start
);

  import dpwm_pkg::*;

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] PERIOD_D = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] INIT_D   = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W:0]   PERIOD_X = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_X   = (CNT_W+1)'(STEP);

  logic             slow_q;
  logic             tick_c;
  logic             up_s;
  logic             dn_s;
  logic             up_rise_c;
  logic             dn_rise_c;
  logic             unused_sync;

  btn_state_e       state;
  btn_state_e       state_nxt;
  logic [CNT_W-1:0] duty_pending;
  logic [CNT_W-1:0] pending_nxt;
  logic [CNT_W:0]   sum_c;
  logic [CNT_W:0]   diff_c;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] duty_nxt;
  logic             wrap_c;

  // slow_clk is sampled as data; its rising edge is the button sampling strobe.
  dpwm_sync_edge #(.EDGE_EN(1'b1)) u_sync_slow (
    .clk    (clk),
    .reset  (reset),
    .d      (slow_clk),
    .q      (slow_q),
    .rise_c (tick_c)
  );

  dpwm_sync_edge #(.EDGE_EN(1'b0)) u_sync_up (
    .clk    (clk),
    .reset  (reset),
    .d      (btn_up),
    .q      (up_s),
    .rise_c (up_rise_c)
  );

  dpwm_sync_edge #(.EDGE_EN(1'b0)) u_sync_dn (
    .clk    (clk),
    .reset  (reset),
    .d      (btn_down),
    .q      (dn_s),
    .rise_c (dn_rise_c)
  );

  assign unused_sync = slow_q ^ up_rise_c ^ dn_rise_c;

  // Button FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Button FSM next state: one step per press, no auto-repeat while held.
  always_comb begin
    state_nxt = state;
    if (tick_c) begin
      case (state)
        IDLE:    if (up_s || dn_s)   state_nxt = HELD;
        HELD:    if (!up_s && !dn_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Button FSM output: saturating step of the pending duty on a fresh press.
  always_comb begin
    sum_c       = {1'b0, duty_pending} + STEP_X;
    diff_c      = {1'b0, duty_pending} - STEP_X;
    pending_nxt = duty_pending;
    if (tick_c && (state == IDLE)) begin
      if (up_s && !dn_s)
        pending_nxt = (sum_c > PERIOD_X) ? PERIOD_D : sum_c[CNT_W-1:0];
      else if (dn_s && !up_s)
        pending_nxt = diff_c[CNT_W] ? '0 : diff_c[CNT_W-1:0];
    end
  end

  // Pending duty register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) duty_pending <= INIT_D;
    else        duty_pending <= pending_nxt;
  end

  // Period counter next values; duty only changes at the wrap.
  always_comb begin
    wrap_c   = (cnt == LAST);
    cnt_nxt  = wrap_c ? '0 : cnt + CNT_W'(1);
    duty_nxt = wrap_c ? duty_pending : duty;
  end

  // Counter, active duty and registered PWM aligned with cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= LAST;
      duty         <= INIT_D;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      duty         <= duty_nxt;
      period_start <= wrap_c;
      pwm_out      <= (cnt_nxt < duty_nxt);
    end
  end

endmodule
